dff_link_ring: RTL and testbench

DFF_LINK_RING -- requirements
Module: dff_link_ring

---
 rtl/dff_ring_defs.sv | 13 +
 rtl/dff_ring_stage.sv | 17 +
 rtl/dff_link_ring.sv | 62 ++++++
 tb/tb_dff_link_ring.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/dff_ring_defs.sv
// dff_ring_defs: shared constants and helpers for the link ring
package dff_ring_defs;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/dff_ring_stage.sv
// dff_ring_stage: one ring register with async reset, sync clear and load enable
module dff_ring_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] nxt;
  always_comb nxt = clr ? '0 : ld ? d : q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= nxt;
endmodule

// File: rtl/dff_link_ring.sv
// dff_link_ring: shift-in / bidirectional rotate register ring with fill and wrap tracking
module dff_link_ring
  import dff_ring_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW = clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic             WR,
  input  logic             DIR,
  input  logic [WIDTH-1:0] input_data,
  input  logic [PW-1:0]    TAP_SEL,
  output logic [WIDTH-1:0] output_data,
  output logic [WIDTH-1:0] tap_data,
  output logic [PW:0]      fill_count,
  output logic             FULL,
  output logic             WRAP
);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [WIDTH-1:0] stg [DEPTH];
  logic [PW-1:0]    rot_pos;
  logic             bwd;
  assign bwd = !WR && DIR == DIR_BWD;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    localparam int P = (i + DEPTH - 1) % DEPTH;
    localparam int N = (i + 1) % DEPTH;
    logic [WIDTH-1:0] d;
    assign d = (WR && i == 0) ? input_data : bwd ? stg[N] : stg[P];
    dff_ring_stage #(.WIDTH(WIDTH)) u_stg (
      .clk(CLK), .rst_n(RST), .clr(CLR), .ld(EN), .d(d), .q(stg[i])
    );
  end
  assign output_data = stg[DEPTH-1];
  assign tap_data    = (32'(TAP_SEL) < DEPTH) ? stg[TAP_SEL] : '0;
  assign FULL        = fill_count == (PW+1)'(DEPTH);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      fill_count <= '0;
      rot_pos    <= '0;
      WRAP       <= 1'b0;
    end else if (CLR) begin
      fill_count <= '0;
      rot_pos    <= '0;
      WRAP       <= 1'b0;
    end else if (!EN) begin
      WRAP <= 1'b0;
    end else if (WR) begin
      fill_count <= FULL ? fill_count : fill_count + 1'b1;
      rot_pos    <= '0;
      WRAP       <= 1'b0;
    end else if (bwd) begin
      rot_pos <= (rot_pos == '0) ? LAST : rot_pos - 1'b1;
      WRAP    <= rot_pos == '0;
    end else begin
      rot_pos <= (rot_pos == LAST) ? '0 : rot_pos + 1'b1;
      WRAP    <= rot_pos == LAST;
    end
endmodule

// File: tb/tb_dff_link_ring.sv
// tb_dff_link_ring: vector table, directed corners and random ops against a queue model
module tb_dff_link_ring;
  localparam int W = 8;
  localparam int D = 4;
  logic CLK = 0, RST = 0, EN = 0, CLR = 0, WR = 0, DIR = 0;
  logic [W-1:0] input_data = '0;
  logic [1:0] TAP_SEL = '0;
  logic [W-1:0] output_data, tap_data;
  logic [2:0] fill_count;
  logic FULL, WRAP;
  int n_cmp = 0, n_err = 0;

  dff_link_ring #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .WR(WR), .DIR(DIR),
    .input_data(input_data), .TAP_SEL(TAP_SEL), .output_data(output_data),
    .tap_data(tap_data), .fill_count(fill_count), .FULL(FULL), .WRAP(WRAP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic en, clr, wr, dir;
    logic [7:0] din;
    logic [1:0] tap;
    logic [7:0] e_out, e_tap;
    logic [2:0] e_fill;
    logic e_full, e_wrap;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int o, input int t, input int f, input int fu, input int wr);
    chk({tag, " out"}, int'(output_data), o);
    chk({tag, " tap"}, int'(tap_data), t);
    chk({tag, " fill"}, int'(fill_count), f);
    chk({tag, " full"}, int'(FULL), fu);
    chk({tag, " wrap"}, int'(WRAP), wr);
  endtask

  task automatic step(input logic en, input logic clr, input logic wr, input logic dir, input logic [7:0] din, input logic [1:0] tap);
    EN = en; CLR = clr; WR = wr; DIR = dir; input_data = din; TAP_SEL = tap;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 0;
    EN = 0; CLR = 0; WR = 0; DIR = 0; input_data = '0; TAP_SEL = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1;
  endtask

  logic [7:0] mq[$];
  int mpos, mfill;
  bit mwrap;

  task automatic m_reset();
    mq = {8'h0, 8'h0, 8'h0, 8'h0};
    mpos = 0; mfill = 0; mwrap = 0;
  endtask

  task automatic m_apply(input bit en, input bit clr, input bit wr, input bit dir, input logic [7:0] din);
    if (clr) m_reset();
    else if (!en) mwrap = 0;
    else if (wr) begin
      mq.push_front(din);
      void'(mq.pop_back());
      mfill = (mfill < D) ? mfill + 1 : D;
      mpos = 0; mwrap = 0;
    end else if (!dir) begin
      mq.push_front(mq.pop_back());
      mwrap = (mpos == D - 1);
      mpos = (mpos + 1) % D;
    end else begin
      mq.push_back(mq.pop_front());
      mwrap = (mpos == 0);
      mpos = (mpos + D - 1) % D;
    end
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1,0,1,0,8'h11,0, 8'h00,8'h11,1,0,0};
    tbl[1]  = '{1,0,1,0,8'h22,0, 8'h00,8'h22,2,0,0};
    tbl[2]  = '{1,0,1,0,8'h33,0, 8'h00,8'h33,3,0,0};
    tbl[3]  = '{1,0,1,0,8'h44,0, 8'h11,8'h44,4,1,0};
    tbl[4]  = '{1,0,0,0,8'h00,0, 8'h22,8'h11,4,1,0};
    tbl[5]  = '{1,0,0,0,8'h00,0, 8'h33,8'h22,4,1,0};
    tbl[6]  = '{1,0,0,0,8'h00,0, 8'h44,8'h33,4,1,0};
    tbl[7]  = '{1,0,0,0,8'h00,0, 8'h11,8'h44,4,1,1};
    tbl[8]  = '{0,0,1,1,8'hee,2, 8'h11,8'h22,4,1,0};
    tbl[9]  = '{1,0,0,1,8'h00,0, 8'h44,8'h33,4,1,1};
    tbl[10] = '{1,0,1,1,8'h55,0, 8'h11,8'h55,4,1,0};
    tbl[11] = '{1,1,1,0,8'h99,0, 8'h00,8'h00,0,0,0};

    do_reset();
    #1;
    chk_all("reset", int'(output_data), 0, 0, 0, 0);
    chk("reset out", int'(output_data), 0);

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].clr, tbl[i].wr, tbl[i].dir, tbl[i].din, tbl[i].tap);
      chk_all($sformatf("vec%0d", i), tbl[i].e_out, tbl[i].e_tap, tbl[i].e_fill, tbl[i].e_full, tbl[i].e_wrap);
    end

    // Write while full from a freshly filled ring drops the oldest entry
    do_reset();
    foreach (tbl[i]) if (i < 4) step(1, 0, 1, 0, tbl[i].din, 0);
    step(1, 0, 1, 0, 8'h55, 0);
    chk_all("wr_full", 8'h22, 8'h55, 4, 1, 0);

    // Async reset asserted between edges mid-rotation
    step(1, 0, 0, 0, 8'h00, 3);
    #2 RST = 0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    @(posedge CLK);
    #1 RST = 1;
    step(1, 0, 1, 0, 8'hab, 0);
    chk_all("post_rst", 0, 8'hab, 1, 0, 0);

    do_reset();
    m_reset();
    for (int k = 0; k < 400; k++) begin
      logic en, clr, wr, dir;
      logic [7:0] din;
      logic [1:0] tap;
      en = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 39) == 0);
      wr = $urandom_range(0, 1) == 1;
      dir = $urandom_range(0, 1) == 1;
      din = 8'($urandom);
      tap = 2'($urandom);
      step(en, clr, wr, dir, din, tap);
      m_apply(en, clr, wr, dir, din);
      chk_all($sformatf("rnd%0d", k), mq[D-1], mq[tap], mfill, int'(mfill == D), int'(mwrap));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
